// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues in-order fetches under a credit limit,
// buffers returned instructions with their PC and restarts cleanly on redirect.
module if_prefetch_unit #(
  parameter int          PC_W     = 9,
  parameter int          INS_W    = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [INS_W-1:0] imem_resp_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [INS_W-1:0] out_insn
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0]      tag_mem  [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [INS_W-1:0] insn_mem [DEPTH];

  logic        discarding;
  logic        req_fire, push, pop;
  logic [CW:0] credit_used;

  // Credits count buffered entries plus live (non-discarded) requests in flight.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q} - {1'b0, discard_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q[PC_W-1:0];
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]   : '0;
  assign out_insn  = out_valid ? insn_mem[rd_ptr_q] : '0;

  assign push = imem_resp_valid && !discarding && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = (discard_d != '0) ? FLUSH : RUN;
  end

  always_comb begin
    discarding = (state_q == FLUSH);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_d    = redirect_pc;
      outstanding_d = outstanding_q - CW'(imem_resp_valid);
      discard_d     = outstanding_q - CW'(imem_resp_valid);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      tag_wr_d      = '0;
      tag_rd_d      = '0;
    end else begin
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
      count_d       = count_q + CW'(push) - CW'(pop);
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + 1'b1;
      end
      if (imem_resp_valid && discarding) discard_d = discard_q - 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        tag_rd_d = tag_rd_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      assert (!(push && !pop && (count_q == CW'(DEPTH))));
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
      insn_mem[wr_ptr_q] <= imem_resp_insn;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: in-order latency memory model plus a stream-level
// scoreboard of expected PCs, live credits and buffered instructions.
module tb_if_prefetch_unit;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b1;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_resp_valid = 1'b0;
  logic [INS_W-1:0] imem_resp_insn = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_pc;
  logic [INS_W-1:0] out_insn;

  if_prefetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_insn(imem_resp_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insn(out_insn)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Memory model: in-order queue of outstanding requests with due cycles.
  int              mem_lat = 1;
  bit              rand_lat = 1'b0;
  logic [PC_W-1:0] q_addr[$];
  int              q_due[$];
  bit              q_stale[$];
  int              last_due = -1;
  bit              resp_stale = 1'b0;

  // Stream-level reference: instructions ready for decode and expected PCs.
  int          avail = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] req_pc = 32'h0;

  logic             obs_out_valid, obs_req_valid, obs_hs, obs_ohs;
  logic [31:0]      obs_out_pc;
  logic [INS_W-1:0] obs_out_insn;
  logic [PC_W-1:0]  obs_req_addr;

  function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {7'h55, a, 7'h2B, a};
  endfunction

  // One clock cycle: sample at negedge, score against the model, advance model.
  task automatic step();
    int useful;
    bit exp_req, hs, ohs;
    int lat;
    @(negedge clock);
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_out_insn  = out_insn;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    useful = 0;
    foreach (q_stale[i]) if (!q_stale[i]) useful++;
    if (imem_resp_valid && !resp_stale) useful++;
    exp_req = !reset && !redirect_valid && ((avail + useful) < DEPTH);
    checks++;
    if (obs_req_valid !== exp_req) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, obs_req_valid, exp_req);
    end
    hs = (obs_req_valid === 1'b1) && imem_req_ready;
    obs_hs = hs;
    if (hs) begin
      checks++;
      if (obs_req_addr !== req_pc[PC_W-1:0]) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, obs_req_addr, req_pc[PC_W-1:0]);
      end
    end
    if (!reset) begin
      checks++;
      if (obs_out_valid !== (avail > 0)) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, obs_out_valid, (avail > 0));
      end
      if (obs_out_valid === 1'b1 && avail > 0) begin
        checks++;
        if (obs_out_pc !== exp_pc || obs_out_insn !== mem_word(exp_pc[PC_W-1:0])) begin
          errors++;
          $display("FAIL out_data cyc=%0d got pc=%h insn=%h exp pc=%h insn=%h",
                   cyc, obs_out_pc, obs_out_insn, exp_pc, mem_word(exp_pc[PC_W-1:0]));
        end
      end
    end
    ohs = (obs_out_valid === 1'b1) && out_ready;
    obs_ohs = ohs && !redirect_valid && !reset;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      q_addr.delete(); q_due.delete(); q_stale.delete();
      last_due = -1; avail = 0; exp_pc = 32'h0; req_pc = 32'h0;
    end else if (redirect_valid) begin
      foreach (q_stale[i]) q_stale[i] = 1'b1;
      avail = 0; exp_pc = redirect_pc; req_pc = redirect_pc;
    end else begin
      if (imem_resp_valid && !resp_stale) avail++;
      if (ohs && avail > 0) begin
        avail--;
        exp_pc = exp_pc + 32'd4;
      end
      if (hs) begin
        lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        last_due = ((cyc - 1 + lat) > last_due) ? (cyc - 1 + lat) : (last_due + 1);
        q_addr.push_back(obs_req_addr); q_due.push_back(last_due); q_stale.push_back(1'b0);
        req_pc = req_pc + 32'd4;
      end
    end
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_insn  = mem_word(q_addr[0]);
      resp_stale      = q_stale[0];
      void'(q_addr.pop_front()); void'(q_due.pop_front()); void'(q_stale.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_insn  = $urandom;
      resp_stale      = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_req_valid !== 1'b0 || obs_out_pc !== 32'h0 || obs_out_insn !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b req=%b pc=%h insn=%h exp all 0",
               obs_out_valid, obs_req_valid, obs_out_pc, obs_out_insn);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int first_valid = -1;
    do_reset();
    mem_lat = 1; rand_lat = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k < 3) begin
        checks++;
        if (!obs_hs || obs_req_addr !== 9'(4 * k)) begin
          errors++;
          $display("FAIL stream_req k=%0d got hs=%b addr=%h exp addr=%h", k, obs_hs, obs_req_addr, 9'(4 * k));
        end
      end
      if (first_valid < 0 && obs_out_valid === 1'b1) first_valid = k;
      if (k >= 2 && k < 10) begin
        checks++;
        if (obs_out_valid !== 1'b1 || obs_out_pc !== 32'(4 * (k - 2))) begin
          errors++;
          $display("FAIL stream_out k=%0d got valid=%b pc=%h exp pc=%h", k, obs_out_valid, obs_out_pc, 32'(4 * (k - 2)));
        end
      end
    end
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL stream_latency got first_valid=%0d exp=2", first_valid);
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    mem_lat = 1; out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs_hs) nreq++;
    end
    checks++;
    if (nreq != DEPTH || obs_req_valid !== 1'b0 || obs_out_valid !== 1'b1 || obs_out_pc !== 32'h0) begin
      errors++;
      $display("FAIL backpressure got reqs=%0d req_valid=%b out_valid=%b pc=%h exp reqs=%0d 0 1 0",
               nreq, obs_req_valid, obs_out_valid, obs_out_pc, DEPTH);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (!obs_ohs || obs_out_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL release k=%0d got pop=%b pc=%h exp pc=%h", k, obs_ohs, obs_out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_flush();
    bit found = 1'b0;
    bit got = 1'b0;
    do_reset();
    mem_lat = 3;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (obs_hs && obs_req_addr == 9'h18) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL flush_setup got no request for 0x18 within bound exp one");
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cleared got out_valid=%b exp 0", obs_out_valid);
    end
    for (int k = 0; k < 30 && !got; k++) begin
      step();
      if (obs_ohs) begin
        got = 1'b1;
        checks++;
        if (obs_out_pc !== 32'h40) begin
          errors++;
          $display("FAIL flush_first got pc=%h exp pc=00000040", obs_out_pc);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL flush_timeout got no delivery exp pc=00000040");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit resp_seen;
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 6; k++) step();
    resp_seen = imem_resp_valid;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (!resp_seen || obs_out_valid !== 1'b1 || out_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_setup got resp=%b out_valid=%b exp 1 1", resp_seen, obs_out_valid);
    end
    step();
    checks++;
    if (obs_out_valid !== 1'b0 || !obs_hs || obs_req_addr !== 9'h100) begin
      errors++;
      $display("FAIL same_cycle_t1 got valid=%b hs=%b addr=%h exp 0 1 100", obs_out_valid, obs_hs, obs_req_addr);
    end
    step();
    step();
    checks++;
    if (obs_out_valid !== 1'b1 || obs_out_pc !== 32'h100) begin
      errors++;
      $display("FAIL same_cycle_t3 got valid=%b pc=%h exp 1 00000100", obs_out_valid, obs_out_pc);
    end
  endtask

  task automatic test_double_redirect();
    bit got = 1'b0;
    do_reset();
    mem_lat = 4;
    for (int k = 0; k < 8; k++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (obs_ohs) begin
        got = 1'b1;
        checks++;
        if (obs_out_pc !== 32'h80) begin
          errors++;
          $display("FAIL double_first got pc=%h exp pc=00000080", obs_out_pc);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL double_timeout got no delivery exp pc=00000080");
    end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    do_reset();
    mem_lat = 2;
    for (int k = 0; k < 6; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_out_pc !== 32'h0 || obs_out_insn !== '0) begin
      errors++;
      $display("FAIL midreset_out got valid=%b pc=%h insn=%h exp all 0", obs_out_valid, obs_out_pc, obs_out_insn);
    end
    for (int k = 0; k < 30 && n < 4; k++) begin
      step();
      if (obs_ohs) begin
        checks++;
        if (obs_out_pc !== 32'(4 * n)) begin
          errors++;
          $display("FAIL midreset_seq n=%0d got pc=%h exp pc=%h", n, obs_out_pc, 32'(4 * n));
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midreset_count got %0d deliveries exp 4", n);
    end
  endtask

  task automatic test_random();
    int delivered = 0;
    int redirects = 0;
    do_reset();
    rand_lat = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {$urandom, 2'b00} >> 2 << 2;
      reset          = ($urandom_range(0, 399) == 0);
      if (redirect_valid) redirects++;
      step();
      if (obs_ohs) delivered++;
    end
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    rand_lat = 1'b0;
    checks++;
    if (delivered < 500 || redirects == 0) begin
      errors++;
      $display("FAIL random_activity got delivered=%0d redirects=%0d exp >=500 and >0", delivered, redirects);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_double_redirect();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
